// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: multiplexed address/data bus sequencer for the RTC with burst read/write
module rtc_bus_sequencer #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int LW    = 4,
    parameter int CW    = 8,
    parameter int T_AS  = 10,
    parameter int T_AH  = 10,
    parameter int T_PW  = 10,
    parameter int T_REC = 10
) (
    input  logic          clk,
    input  logic          resetcounterdireccion,
    input  logic          start,
    input  logic          rnw,
    input  logic [AW-1:0] addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] wdata,
    input  logic          abort,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    output logic          cs_n,
    output logic          rd_n,
    output logic          wr_n,
    output logic          as,
    output logic [DW-1:0] rdata,
    output logic          byte_strobe,
    output logic          busy,
    output logic          done
);
    typedef enum logic [2:0] {IDLE, ADDR, HOLD, CMD, REC, DONE} state_t;

    localparam logic [CW-1:0] L_AS  = CW'(T_AS - 1);
    localparam logic [CW-1:0] L_AH  = CW'(T_AH - 1);
    localparam logic [CW-1:0] L_PW  = CW'(T_PW - 1);
    localparam logic [CW-1:0] L_REC = CW'(T_REC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          rnw_q, rnw_d, cancel_q, cancel_d;
    logic [DW-1:0] bus_out_q, bus_out_d, rdata_q, rdata_d;
    logic          bus_oe_q, bus_oe_d, cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic          as_q, as_d, byte_strobe_q, byte_strobe_d, busy_q, busy_d, done_q, done_d;
    logic          last;

    assign last = cnt_q == '0;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q - CW'(1);
        addr_d        = addr_q;
        rem_d         = rem_q;
        rnw_d         = rnw_q;
        cancel_d      = cancel_q;
        rdata_d       = rdata_q;
        byte_strobe_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d  = ADDR;
                cnt_d    = L_AS;
                addr_d   = addr;
                rnw_d    = rnw;
                rem_d    = len;
                cancel_d = 1'b0;
            end
            ADDR: if (abort) begin
                state_d  = REC;
                cnt_d    = L_REC;
                cancel_d = 1'b1;
            end else if (last) begin
                state_d = HOLD;
                cnt_d   = L_AH;
            end
            HOLD: if (abort) begin
                state_d  = REC;
                cnt_d    = L_REC;
                cancel_d = 1'b1;
            end else if (last) begin
                state_d = CMD;
                cnt_d   = L_PW;
            end
            CMD: if (abort || last) begin
                state_d       = REC;
                cnt_d         = L_REC;
                cancel_d      = cancel_q | abort;
                byte_strobe_d = !abort;
                rdata_d       = (rnw_q && !abort) ? bus_in : rdata_q;
            end
            REC: begin
                cancel_d = cancel_q | abort;
                if (last) begin
                    state_d = (rem_q != '0 && !cancel_d) ? ADDR : DONE;
                    cnt_d   = L_AS;
                    addr_d  = (rem_q != '0 && !cancel_d) ? addr_q + AW'(1) : addr_q;
                    rem_d   = (rem_q != '0 && !cancel_d) ? rem_q - LW'(1) : rem_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        as_d      = state_d == ADDR;
        cs_n_d    = state_d != CMD;
        rd_n_d    = !(state_d == CMD && rnw_d);
        wr_n_d    = !(state_d == CMD && !rnw_d);
        bus_oe_d  = state_d == ADDR || state_d == HOLD || (state_d == CMD && !rnw_d);
        busy_d    = state_d != IDLE;
        done_d    = state_d == DONE;
        // write data is taken from wdata only on the edge entering CMD, then held
        bus_out_d = (state_d == ADDR || state_d == HOLD) ? DW'(addr_d) :
                    (state_d == CMD && !rnw_d) ? (state_q == CMD ? bus_out_q : wdata) : '0;
    end

    always_ff @(posedge clk or negedge resetcounterdireccion) begin
        if (!resetcounterdireccion) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            rem_q         <= '0;
            rnw_q         <= 1'b0;
            cancel_q      <= 1'b0;
            rdata_q       <= '0;
            bus_out_q     <= '0;
            bus_oe_q      <= 1'b0;
            cs_n_q        <= 1'b1;
            rd_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            as_q          <= 1'b0;
            byte_strobe_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            rnw_q         <= rnw_d;
            cancel_q      <= cancel_d;
            rdata_q       <= rdata_d;
            bus_out_q     <= bus_out_d;
            bus_oe_q      <= bus_oe_d;
            cs_n_q        <= cs_n_d;
            rd_n_q        <= rd_n_d;
            wr_n_q        <= wr_n_d;
            as_q          <= as_d;
            byte_strobe_q <= byte_strobe_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus_out     = bus_out_q;
    assign bus_oe      = bus_oe_q;
    assign cs_n        = cs_n_q;
    assign rd_n        = rd_n_q;
    assign wr_n        = wr_n_q;
    assign as          = as_q;
    assign rdata       = rdata_q;
    assign byte_strobe = byte_strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed-vector bench for rtc_bus_sequencer
module tb_rtc_bus_sequencer;
    logic       clk = 1'b0;
    logic       resetcounterdireccion;
    logic       start, rnw, abort;
    logic [7:0] addr, wdata, bus_in;
    logic [3:0] len;
    logic [7:0] bus_out, rdata;
    logic       bus_oe, cs_n, rd_n, wr_n, as, byte_strobe, busy, done;
    logic       start2, rnw2, abort2;
    logic [7:0] addr2, wdata2, bus_in2;
    logic [3:0] len2;
    logic [7:0] bus_out2, rdata2;
    logic       bus_oe2, cs_n2, rd_n2, wr_n2, as2, byte_strobe2, busy2, done2;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    rtc_bus_sequencer dut (
        .clk(clk), .resetcounterdireccion(resetcounterdireccion), .start(start), .rnw(rnw),
        .addr(addr), .len(len), .wdata(wdata), .abort(abort), .bus_in(bus_in),
        .bus_out(bus_out), .bus_oe(bus_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .as(as),
        .rdata(rdata), .byte_strobe(byte_strobe), .busy(busy), .done(done)
    );

    rtc_bus_sequencer #(.T_AS(1), .T_AH(1), .T_PW(1), .T_REC(1)) dut_fast (
        .clk(clk), .resetcounterdireccion(resetcounterdireccion), .start(start2), .rnw(rnw2),
        .addr(addr2), .len(len2), .wdata(wdata2), .abort(abort2), .bus_in(bus_in2),
        .bus_out(bus_out2), .bus_oe(bus_oe2), .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2), .as(as2),
        .rdata(rdata2), .byte_strobe(byte_strobe2), .busy(busy2), .done(done2)
    );

    // ph: 0 idle, 1 addr, 2 hold, 3 cmd, 4 rec, 5 done
    function automatic logic [7:0] ctl(input int ph, input logic rd, input logic bs);
        return {ph == 1, ph != 3, !(ph == 3 && rd), !(ph == 3 && !rd),
                ph == 1 || ph == 2 || (ph == 3 && !rd), ph != 0, ph == 5, bs};
    endfunction

    function automatic int phase(input int c, input int n);
        int k;
        if (c < 1 || c > n * 40 + 1) return 0;
        if (c == n * 40 + 1) return 5;
        k = (c - 1) % 40;
        return k < 10 ? 1 : k < 20 ? 2 : k < 30 ? 3 : 4;
    endfunction

    function automatic logic [7:0] obs1();
        return {as, cs_n, rd_n, wr_n, bus_oe, busy, done, byte_strobe};
    endfunction

    task automatic test_reset();
        resetcounterdireccion = 1'b0;
        start = 0; rnw = 0; abort = 0; addr = 0; len = 0; wdata = 0; bus_in = 0;
        start2 = 0; rnw2 = 0; abort2 = 0; addr2 = 0; len2 = 0; wdata2 = 0; bus_in2 = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs1() !== 8'b0111_0000) begin
            errors++; $display("FAIL reset_ctl got %b expected %b", obs1(), 8'b0111_0000);
        end
        checks++;
        if (bus_out !== 8'h00 || rdata !== 8'h00) begin
            errors++; $display("FAIL reset_data got bus_out=%h rdata=%h expected 00 00", bus_out, rdata);
        end
        resetcounterdireccion = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs1() !== 8'b0111_0000) begin
            errors++; $display("FAIL idle_after_reset got %b expected %b", obs1(), 8'b0111_0000);
        end
    endtask

    task automatic run_txn(input string name, input logic rd, input logic [7:0] a,
                           input logic [3:0] l, input logic [7:0] wd, input logic [7:0] base);
        int n, ph, b;
        logic bs;
        logic [7:0] e;
        n = int'(l) + 1;
        @(negedge clk);
        start = 1; rnw = rd; addr = a; len = l; wdata = wd;
        for (int c = 1; c <= n * 40 + 2; c++) begin
            @(negedge clk);
            start = 0;
            ph = phase(c, n);
            b  = (c - 1) / 40;
            bs = ph == 4 && (c - 1) % 40 == 30;
            e  = ctl(ph, rd, bs);
            checks++;
            if (obs1() !== e) begin
                errors++; $display("FAIL %s_ctl cycle %0d got %b expected %b", name, c, obs1(), e);
            end
            if (ph == 1 || ph == 2) begin
                checks++;
                if (bus_out !== 8'(a + 8'(b))) begin
                    errors++; $display("FAIL %s_addr cycle %0d got %h expected %h", name, c, bus_out, 8'(a + 8'(b)));
                end
            end
            if (ph == 3 && !rd) begin
                checks++;
                if (bus_out !== wd) begin
                    errors++; $display("FAIL %s_wdata cycle %0d got %h expected %h", name, c, bus_out, wd);
                end
            end
            if (rd && bs) begin
                checks++;
                if (rdata !== 8'(base + 8'(b))) begin
                    errors++; $display("FAIL %s_rdata cycle %0d got %h expected %h", name, c, rdata, 8'(base + 8'(b)));
                end
            end
            bus_in = 8'(base + 8'((c - 1) / 40));
        end
    endtask

    task automatic test_write();
        run_txn("write", 1'b0, 8'h0A, 4'd0, 8'h26, 8'h00);
    endtask

    task automatic test_read();
        run_txn("read", 1'b1, 8'h0C, 4'd0, 8'h00, 8'h5A);
    endtask

    task automatic test_burst_wrap();
        run_txn("burst", 1'b1, 8'hFF, 4'd2, 8'h00, 8'h40);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1; rnw = 0; addr = 8'h21; len = 0; wdata = 8'h3C;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 0;
        end
        checks++;
        if (bus_oe !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset got oe=%b busy=%b expected 1 1", bus_oe, busy);
        end
        resetcounterdireccion = 1'b0;
        #1;
        checks++;
        if (obs1() !== 8'b0111_0000 || bus_out !== 8'h00 || rdata !== 8'h00) begin
            errors++; $display("FAIL async_reset got ctl=%b bus_out=%h rdata=%h expected 01110000 00 00", obs1(), bus_out, rdata);
        end
        @(negedge clk);
        resetcounterdireccion = 1'b1;
        @(negedge clk);
        run_txn("after_reset", 1'b0, 8'h21, 4'd0, 8'h3C, 8'h00);
    endtask

    task automatic test_abort();
        int ph;
        logic [7:0] e;
        @(negedge clk);
        start = 1; rnw = 0; addr = 8'h33; len = 4'd3; wdata = 8'h99;
        for (int c = 1; c <= 37; c++) begin
            @(negedge clk);
            start = 0;
            ph = c <= 10 ? 1 : c <= 20 ? 2 : c <= 25 ? 3 : c <= 35 ? 4 : c == 36 ? 5 : 0;
            e  = ctl(ph, 1'b0, 1'b0);
            checks++;
            if (obs1() !== e) begin
                errors++; $display("FAIL abort_ctl cycle %0d got %b expected %b", c, obs1(), e);
            end
            abort = c == 25;
        end
        abort = 0;
    endtask

    task automatic test_back_to_back();
        int k, ph;
        logic [7:0] e, o;
        @(negedge clk);
        start2 = 1; rnw2 = 0; addr2 = 8'h10; len2 = 0; wdata2 = 8'h77;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            k  = (c - 1) % 6;
            ph = k == 5 ? 0 : k + 1;
            e  = ctl(ph, 1'b0, k == 3);
            o  = {as2, cs_n2, rd_n2, wr_n2, bus_oe2, busy2, done2, byte_strobe2};
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL b2b_ctl cycle %0d got %b expected %b", c, o, e);
            end
            if (ph == 3) begin
                checks++;
                if (bus_out2 !== 8'h77) begin
                    errors++; $display("FAIL b2b_wdata cycle %0d got %h expected 77", c, bus_out2);
                end
            end
        end
        start2 = 0;
        repeat (8) @(negedge clk);
        checks++;
        if (busy2 !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got busy=%b expected 0", busy2);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_burst_wrap();
        test_async_reset();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
